bsg_axil_to_fifos_tx: RTL and testbench

AXI4-Lite write-channel slave that turns host writes into pushes onto one of num_fifos_p outbound 32-bit valid/ready FIFO interfaces. It is the transmit-side companion of the AXI-Lite read/rx adapter and uses the same address map: one window of 2^base_addr_width_p bytes per FIFO, with a transmit data register (TDR) at a fixed offset in each window. Each write completes with exactly one B response. The response is OKAY for a successful push, SLVERR for an unsupported register or partial strobe, and DECERR for an unmapped address.

---
 rtl/bsg_axil_to_fifos_tx.sv | 146 ++++++++++++++
 tb/tb_bsg_axil_to_fifos_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_axil_to_fifos_tx.sv
`default_nettype none
// ============================================================================
// Module   : bsg_axil_to_fifos_tx
// Brief    : AXI4-Lite write slave that turns writes to a per-FIFO transmit
//            data register (TDR) into pushes on outbound valid/ready FIFOs.
//            Each write gets exactly one B response (OKAY/SLVERR/DECERR).
// Revision : 1.0 - initial release
// ============================================================================
module bsg_axil_to_fifos_tx #(
  parameter int                           num_fifos_p       = 2,
  parameter int                           base_addr_width_p = 8,
  parameter logic [31:0]                  axil_base_addr_p  = 32'h0000_0000,
  parameter logic [base_addr_width_p-1:0] ofs_tdr_p         = base_addr_width_p'('h10)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic [31:0]                  awaddr_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,

  input  logic [31:0]                  wdata_i,
  input  logic [3:0]                   wstrb_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,

  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,

  output logic [num_fifos_p-1:0]       tx_v_o,
  output logic [num_fifos_p-1:0][31:0] tx_data_o,
  input  logic [num_fifos_p-1:0]       tx_ready_i
);

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  typedef enum logic [1:0] {
    E_WR_COLLECT = 2'd0,
    E_WR_PUSH    = 2'd1,
    E_WR_RESP    = 2'd2
  } state_e;

  state_e      state_r;
  logic        aw_got_r;
  logic        w_got_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic [3:0]  strb_r;
  logic [1:0]  bresp_r;

  logic                   w_in_collect;
  logic                   w_in_push;
  logic                   w_in_resp;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic [num_fifos_p-1:0] w_idx_hit;
  logic                   w_any_hit;
  logic                   w_tdr;
  logic                   w_push;
  logic                   w_push_ready;
  logic [1:0]             w_err_resp;

  // Reset masks every output in the same cycle, so state is qualified here.
  assign w_in_collect = (state_r == E_WR_COLLECT) && !reset_i;
  assign w_in_push    = (state_r == E_WR_PUSH)    && !reset_i;
  assign w_in_resp    = (state_r == E_WR_RESP)    && !reset_i;

  assign awready_o = w_in_collect && !aw_got_r;
  assign wready_o  = w_in_collect && !w_got_r;
  assign w_aw_hs   = awvalid_i && awready_o;
  assign w_w_hs    = wvalid_i && wready_o;

  // One comparator per FIFO window; indices are distinct so at most one hits.
  for (genvar i = 0; i < num_fifos_p; i++) begin : g_decode
    localparam logic [31:0] c_idx = 32'(i) + (axil_base_addr_p >> base_addr_width_p);
    assign w_idx_hit[i] = (addr_r[31:base_addr_width_p] == c_idx[31-base_addr_width_p:0]);
    assign tx_data_o[i] = data_r;
  end

  // Low address bits are compared in full, so unaligned TDR accesses miss.
  assign w_any_hit    = |w_idx_hit;
  assign w_tdr        = (addr_r[base_addr_width_p-1:0] == ofs_tdr_p);
  assign w_push       = w_any_hit && w_tdr && (strb_r == 4'hF);
  assign w_push_ready = |(w_idx_hit & tx_ready_i);
  assign w_err_resp   = w_any_hit ? c_resp_slverr : c_resp_decerr;

  assign tx_v_o   = (w_in_push && w_push) ? w_idx_hit : '0;
  assign bvalid_o = w_in_resp;
  assign bresp_o  = w_in_resp ? bresp_r : 2'b00;

  // Write-channel FSM: gather AW and W, push or reject, then hold B.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= E_WR_COLLECT;
      aw_got_r <= 1'b0;
      w_got_r  <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
      strb_r   <= '0;
      bresp_r  <= '0;
    end else begin
      case (state_r)
        E_WR_COLLECT: begin
          if (w_aw_hs) begin
            addr_r   <= awaddr_i;
            aw_got_r <= 1'b1;
          end
          if (w_w_hs) begin
            data_r  <= wdata_i;
            strb_r  <= wstrb_i;
            w_got_r <= 1'b1;
          end
          if ((aw_got_r || w_aw_hs) && (w_got_r || w_w_hs)) begin
            state_r <= E_WR_PUSH;
          end
        end
        E_WR_PUSH: begin
          if (w_push) begin
            if (w_push_ready) begin
              bresp_r <= c_resp_okay;
              state_r <= E_WR_RESP;
            end
          end else begin
            bresp_r <= w_err_resp;
            state_r <= E_WR_RESP;
          end
        end
        E_WR_RESP: begin
          if (bready_i) begin
            aw_got_r <= 1'b0;
            w_got_r  <= 1'b0;
            state_r  <= E_WR_COLLECT;
          end
        end
        default: begin
          state_r <= E_WR_COLLECT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bsg_axil_to_fifos_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_axil_to_fifos_tx
// Brief    : Scoreboard bench for bsg_axil_to_fifos_tx. Stimulus pushes the
//            expected FIFO data and B responses; a negedge monitor pops and
//            compares on every handshake and checks hold/one-hot rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_axil_to_fifos_tx;

  localparam int NF = 2;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic [31:0]       awaddr_i = '0;
  logic              awvalid_i = 1'b0;
  logic              awready_o;
  logic [31:0]       wdata_i = '0;
  logic [3:0]        wstrb_i = '0;
  logic              wvalid_i = 1'b0;
  logic              wready_o;
  logic [1:0]        bresp_o;
  logic              bvalid_o;
  logic              bready_i = 1'b1;
  logic [NF-1:0]     tx_v_o;
  logic [NF-1:0][31:0] tx_data_o;
  logic [NF-1:0]     tx_ready_i = 2'b11;

  bsg_axil_to_fifos_tx #(
    .num_fifos_p      (NF),
    .base_addr_width_p(8),
    .axil_base_addr_p (32'h0000_0000),
    .ofs_tdr_p        (8'h10)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .awaddr_i  (awaddr_i),
    .awvalid_i (awvalid_i),
    .awready_o (awready_o),
    .wdata_i   (wdata_i),
    .wstrb_i   (wstrb_i),
    .wvalid_i  (wvalid_i),
    .wready_o  (wready_o),
    .bresp_o   (bresp_o),
    .bvalid_o  (bvalid_o),
    .bready_i  (bready_i),
    .tx_v_o    (tx_v_o),
    .tx_data_o (tx_data_o),
    .tx_ready_i(tx_ready_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [1:0]  qb[$];

  logic        rand_mode    = 1'b0;
  logic [1:0]  tx_ready_ctl = 2'b11;
  logic        bready_ctl   = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected event expected none", nm);
  endtask

  // Ready/stall driver: directed values, or random stalls in the soak phase.
  always @(posedge clk) begin
    #2;
    if (rand_mode) begin
      tx_ready_i = 2'($urandom_range(0, 3));
      bready_i   = ($urandom_range(0, 3) != 0);
    end else begin
      tx_ready_i = tx_ready_ctl;
      bready_i   = bready_ctl;
    end
  end

  // Monitor: compares handshakes against the scoreboard and checks hold rules.
  logic [1:0]  p_txv = '0;
  logic [1:0]  p_rdy = '0;
  logic [31:0] p_d0 = '0;
  logic [31:0] p_d1 = '0;
  logic        p_bv = 1'b0;
  logic        p_br = 1'b0;
  logic [1:0]  p_bresp = '0;

  always @(negedge clk) begin
    if (reset_i) begin
      chk("reset_outputs_low", 64'({awready_o, wready_o, bvalid_o, tx_v_o, bresp_o}), 64'd0);
    end else begin
      chk("tx_onehot", 64'($countones(tx_v_o) <= 1), 64'd1);
      if (p_txv[0] && !p_rdy[0]) begin
        chk("tx0_hold", 64'(tx_v_o[0]), 64'd1);
        chk("tx0_data_stable", 64'(tx_data_o[0]), 64'(p_d0));
      end
      if (p_txv[1] && !p_rdy[1]) begin
        chk("tx1_hold", 64'(tx_v_o[1]), 64'd1);
        chk("tx1_data_stable", 64'(tx_data_o[1]), 64'(p_d1));
      end
      if (p_bv && !p_br) chk("b_hold", 64'({bvalid_o, bresp_o}), 64'({1'b1, p_bresp}));
      if (bvalid_o) chk("no_accept_in_resp", 64'({awready_o, wready_o}), 64'd0);
      if (tx_v_o[0] && tx_ready_i[0]) begin
        if (q0.size() == 0) fail_now("push0_unexpected");
        else chk("push0_data", 64'(tx_data_o[0]), 64'(q0.pop_front()));
      end
      if (tx_v_o[1] && tx_ready_i[1]) begin
        if (q1.size() == 0) fail_now("push1_unexpected");
        else chk("push1_data", 64'(tx_data_o[1]), 64'(q1.pop_front()));
      end
      if (bvalid_o && bready_i) begin
        if (qb.size() == 0) fail_now("b_unexpected");
        else chk("bresp", 64'(bresp_o), 64'(qb.pop_front()));
      end
    end
    p_txv   = tx_v_o;
    p_rdy   = tx_ready_i;
    p_d0    = tx_data_o[0];
    p_d1    = tx_data_o[1];
    p_bv    = bvalid_o;
    p_br    = bready_i;
    p_bresp = bresp_o;
  end

  // One AXI-Lite write; AW and W each start after their own delay in cycles.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int adly, input int wdly);
    fork
      begin
        int n = 0;
        repeat (adly) begin @(posedge clk); #1; end
        awaddr_i  = a;
        awvalid_i = 1'b1;
        @(negedge clk);
        while (!awready_o && n < 300) begin @(negedge clk); n++; end
        if (!awready_o) fail_now("aw_timeout");
        @(posedge clk); #1;
        awvalid_i = 1'b0;
      end
      begin
        int n = 0;
        repeat (wdly) begin @(posedge clk); #1; end
        wdata_i  = d;
        wstrb_i  = s;
        wvalid_i = 1'b1;
        @(negedge clk);
        while (!wready_o && n < 300) begin @(negedge clk); n++; end
        if (!wready_o) fail_now("w_timeout");
        @(posedge clk); #1;
        wvalid_i = 1'b0;
      end
    join
  endtask

  // Records the expected outcome (fifo < 0 means no push), then issues it.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int adly, input int wdly, input int fifo, input logic [1:0] resp);
    if (fifo == 0) q0.push_back(d);
    if (fifo == 1) q1.push_back(d);
    qb.push_back(resp);
    do_write(a, d, s, adly, wdly);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || qb.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q0.size() != 0 || q1.size() != 0 || qb.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'({awready_o, wready_o, bvalid_o, tx_v_o}), 64'b11000);
    @(posedge clk); #1;

    // Same-cycle AW/W to FIFO1 TDR, exact latency.
    issue(32'h110, 32'hDEADBEEF, 4'hF, 0, 0, 1, 2'b00);
    @(negedge clk);
    chk("lat_txv", 64'(tx_v_o), 64'b10);
    chk("lat_txdata", 64'(tx_data_o[1]), 64'hDEADBEEF);
    @(negedge clk);
    chk("lat_b", 64'({bvalid_o, bresp_o, tx_v_o}), 64'b10000);
    @(negedge clk);
    chk("lat_ready_again", 64'({awready_o, wready_o, bvalid_o}), 64'b110);
    @(posedge clk); #1;

    // W first, AW three cycles later, FIFO0 not ready for 5 cycles.
    tx_ready_ctl = 2'b10;
    issue(32'h010, 32'h12345678, 4'hF, 3, 0, 0, 2'b00);
    begin
      int hi = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (tx_v_o[0]) hi++;
        @(posedge clk); #1;
      end
      tx_ready_ctl = 2'b11;
      @(negedge clk);
      if (tx_v_o[0]) hi++;
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_cycles", 64'(hi), 64'd5);
      chk("stall_released", 64'(tx_v_o), 64'd0);
      @(posedge clk); #1;
    end

    // Error responses.
    issue(32'h300, 32'hAAAA0001, 4'hF, 0, 0, -1, 2'b11);
    issue(32'h014, 32'hAAAA0002, 4'hF, 1, 0, -1, 2'b10);
    issue(32'h010, 32'hAAAA0003, 4'h3, 0, 2, -1, 2'b10);
    issue(32'h011, 32'hAAAA0004, 4'hF, 0, 0, -1, 2'b10);
    drain();

    // B held for several cycles while the next AW/W wait.
    bready_ctl = 1'b0;
    issue(32'h110, 32'h11111111, 4'hF, 0, 0, 1, 2'b00);
    fork
      issue(32'h010, 32'h22222222, 4'hF, 0, 0, 0, 2'b00);
      begin
        repeat (6) begin @(posedge clk); #1; end
        bready_ctl = 1'b1;
      end
    join
    drain();

    // Reset while FIFO0 push is pending: both push and B are dropped.
    tx_ready_ctl = 2'b10;
    issue(32'h010, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'b00);
    @(negedge clk);
    chk("pending_before_reset", 64'(tx_v_o), 64'b01);
    @(posedge clk); #1;
    reset_i = 1'b1;
    void'(q0.pop_back());
    void'(qb.pop_back());
    @(negedge clk);
    chk("tx_drop_in_reset", 64'(tx_v_o), 64'd0);
    @(posedge clk); #1;
    reset_i      = 1'b0;
    tx_ready_ctl = 2'b11;
    repeat (3) begin @(posedge clk); #1; end
    issue(32'h010, 32'h0BADCAFE, 4'hF, 0, 1, 0, 2'b00);
    drain();

    // Random-order soak with random stalls.
    rand_mode = 1'b1;
    for (int k = 0; k < 100; k++) begin
      int f;
      f = int'($urandom_range(0, 1));
      issue((f == 1) ? 32'h110 : 32'h010, $urandom, 4'hF,
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), f, 2'b00);
    end
    rand_mode = 1'b0;
    drain();
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if anything wedges.
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
